imm_encode: RTL and testbench

Immediate encoder for the integer unit: the inverse of the decode-stage immediate extender. Given a base instruction (bits 31:7), an immediate format select and an XLEN-wide immediate value, it scatters the immediate into the format's instruction fields, checks the value is representable, and delivers the result through a 2-entry valid/ready buffer. It sits between the trace/self-test instruction generator and the instruction-injection port, and reports a running count of rejected requests.

---
 rtl/imm_encode.sv | 185 ++++++++++++++++++
 tb/tb_imm_encode.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encode.sv
// Immediate encoder: scatters an XLEN immediate into the I/S/B/J/U instruction
// fields of a base instruction, flags unrepresentable values, and buffers results in a 2-entry FIFO.
package imm_encode_pkg;
  typedef struct packed {
    int XLEN;
    bit A_SUPPORTED;
  } cvw_t;

  localparam cvw_t IMM_ENCODE_DEFAULT_CFG = '{XLEN: 32'sd32, A_SUPPORTED: 1'b1};
endpackage

module imm_encode
  import imm_encode_pkg::*;
#(
  parameter cvw_t P = IMM_ENCODE_DEFAULT_CFG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:7]       InBase,
  input  logic [2:0]        InImmSrc,
  input  logic [P.XLEN-1:0] InImm,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [31:7]       OutInstr,
  output logic              OutErr,
  output logic [7:0]        ErrCount
);

  localparam int XLEN = P.XLEN;

  localparam logic [2:0] FMT_I  = 3'b000;
  localparam logic [2:0] FMT_S  = 3'b001;
  localparam logic [2:0] FMT_B  = 3'b010;
  localparam logic [2:0] FMT_J  = 3'b011;
  localparam logic [2:0] FMT_U  = 3'b100;
  localparam logic [2:0] FMT_SC = 3'b101;

  // True when bits [XLEN-1:lsb] of v are all copies of v[lsb], i.e. v fits a signed field ending at lsb.
  function automatic logic upper_same(input logic [XLEN-1:0] v, input int unsigned lsb);
    logic [XLEN-1:0] shifted;
    shifted = $signed(v) >>> lsb;
    return (shifted == {XLEN{1'b0}}) || (shifted == {XLEN{1'b1}});
  endfunction

  logic [31:7] enc_s;
  logic        legal_s;
  logic [31:7] instr_s;
  logic        err_s;
  logic        push_s;
  logic        pop_s;
  logic [1:0]  count_nxt_s;

  logic [1:0]  count_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic [31:7] head_instr_r;
  logic        head_err_r;
  logic [31:7] tail_instr_r;
  logic        tail_err_r;
  logic [7:0]  err_count_r;

  // Field scatter and representability check for the selected format.
  always_comb begin
    enc_s   = InBase;
    legal_s = 1'b0;
    case (InImmSrc)
      FMT_I: begin
        enc_s[31:20] = InImm[11:0];
        legal_s      = upper_same(InImm, 32'd11);
      end
      FMT_S: begin
        enc_s[31:25] = InImm[11:5];
        enc_s[11:7]  = InImm[4:0];
        legal_s      = upper_same(InImm, 32'd11);
      end
      FMT_B: begin
        enc_s[31]    = InImm[12];
        enc_s[7]     = InImm[11];
        enc_s[30:25] = InImm[10:5];
        enc_s[11:8]  = InImm[4:1];
        legal_s      = !InImm[0] && upper_same(InImm, 32'd12);
      end
      FMT_J: begin
        enc_s[31]    = InImm[20];
        enc_s[19:12] = InImm[19:12];
        enc_s[20]    = InImm[11];
        enc_s[30:21] = InImm[10:1];
        legal_s      = !InImm[0] && upper_same(InImm, 32'd20);
      end
      FMT_U: begin
        enc_s[31:12] = InImm[31:12];
        legal_s      = (InImm[11:0] == 12'd0) && upper_same(InImm, 32'd31);
      end
      FMT_SC: begin
        legal_s = P.A_SUPPORTED && (InImm == {XLEN{1'b0}});
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Unrepresentable requests pass the base instruction through untouched.
  always_comb begin
    if (legal_s) begin
      instr_s = enc_s;
      err_s   = 1'b0;
    end else begin
      instr_s = InBase;
      err_s   = 1'b1;
    end
  end

  // Handshakes use only registered ready/valid, so OutReady never reaches InReady combinationally.
  always_comb begin
    push_s = InValid && in_ready_r;
    pop_s  = out_valid_r && OutReady;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy plus the ready/valid flags that are decoded from it one cycle early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r     <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s != 2'd2);
      out_valid_r <= (count_nxt_s != 2'd0);
    end
  end

  // Head/tail storage: head always drives the outputs; tail only holds the second entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_instr_r <= 25'd0;
      head_err_r   <= 1'b0;
      tail_instr_r <= 25'd0;
      tail_err_r   <= 1'b0;
    end else begin
      if (push_s && ((count_r == 2'd0) || pop_s)) begin
        head_instr_r <= instr_s;
        head_err_r   <= err_s;
      end else if (pop_s && (count_r == 2'd2)) begin
        head_instr_r <= tail_instr_r;
        head_err_r   <= tail_err_r;
      end else begin
        head_instr_r <= head_instr_r;
        head_err_r   <= head_err_r;
      end
      if (push_s && !pop_s && (count_r == 2'd1)) begin
        tail_instr_r <= instr_s;
        tail_err_r   <= err_s;
      end else begin
        tail_instr_r <= tail_instr_r;
        tail_err_r   <= tail_err_r;
      end
    end
  end

  // Rejected-request counter, counted at acceptance and held at its ceiling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_r <= 8'd0;
    end else if (push_s && err_s && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'd1;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign InReady  = in_ready_r;
  assign OutValid = out_valid_r;
  assign OutInstr = head_instr_r;
  assign OutErr   = head_err_r;
  assign ErrCount = err_count_r;

endmodule

// File: tb/tb_imm_encode.sv
// Scoreboard bench for imm_encode: an arithmetic reference model predicts each accepted
// request, a negedge monitor compares every delivered result in order.
module tb_imm_encode;
  import imm_encode_pkg::*;

  logic        clk;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [31:7] InBase;
  logic [2:0]  InImmSrc;
  logic [31:0] InImm;
  logic        OutValid;
  logic        OutReady;
  logic [31:7] OutInstr;
  logic        OutErr;
  logic [7:0]  ErrCount;

  imm_encode dut (
    .clk(clk), .reset(reset),
    .InValid(InValid), .InReady(InReady),
    .InBase(InBase), .InImmSrc(InImmSrc), .InImm(InImm),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutInstr(OutInstr), .OutErr(OutErr), .ErrCount(ErrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  src;
    logic [31:0] imm;
  } exp_t;

  exp_t sb_q[$];
  int compared   = 0;
  int mismatched = 0;
  int model_errs = 0;
  logic [31:0] bnd [0:12] = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFE,
                              32'h1000, 32'hFFFFF000, 32'hFFFFEFFE, 32'hFFFFE,
                              32'h100000, 32'hFFF00000, 32'h0, 32'h1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: range checks on the signed value, fields placed with masks and shifts.
  function automatic exp_t model(input logic [24:0] base25, input logic [2:0] src, input logic [31:0] imm);
    exp_t e;
    logic [31:0] base, ins;
    longint s;
    bit legal;
    base = {base25, 7'b0};
    s = longint'($signed(imm));
    ins = base;
    legal = 1'b0;
    case (src)
      3'd0: begin
        legal = (s >= -2048) && (s <= 2047);
        ins = (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
      end
      3'd1: begin
        legal = (s >= -2048) && (s <= 2047);
        ins = (base & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      3'd2: begin
        legal = ((imm & 32'h1) == 32'h0) && (s >= -4096) && (s <= 4094);
        ins = (base & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 11) & 32'h1) << 7)
            | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
      end
      3'd3: begin
        legal = ((imm & 32'h1) == 32'h0) && (s >= -1048576) && (s <= 1048574);
        ins = (base & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 12) & 32'hFF) << 12)
            | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21);
      end
      3'd4: begin
        legal = ((imm % 32'd4096) == 32'd0);
        ins = (base & 32'h00000FFF) | (imm & 32'hFFFFF000);
      end
      3'd5: legal = (imm == 32'd0);
      default: legal = 1'b0;
    endcase
    e.instr = legal ? ins : base;
    e.err   = !legal;
    e.src   = src;
    e.imm   = imm;
    return e;
  endfunction

  // Decode-stage immediate extender, used to confirm encodings round-trip.
  function automatic logic [31:0] decode(input logic [31:0] ins, input logic [2:0] src);
    case (src)
      3'd0: return {{20{ins[31]}}, ins[31:20]};
      3'd1: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd4: return {ins[31:12], 12'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return $urandom_range(0, 8200) - 32'd4100;
      2: return $urandom & 32'hFFFFF000;
      3: return bnd[$urandom_range(0, 12)];
      default: return $urandom_range(0, 2097156) - 32'd1048578;
    endcase
  endfunction

  function automatic logic [63:0] exp_errs();
    return (model_errs > 255) ? 64'd255 : 64'(model_errs);
  endfunction

  task automatic push_model(input logic [24:0] base, input logic [2:0] src, input logic [31:0] imm);
    exp_t e;
    e = model(base, src, imm);
    sb_q.push_back(e);
    if (e.err) model_errs++;
  endtask

  // Monitor: every delivery handshake is checked against the oldest prediction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && OutValid && OutReady) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got instr 0x%0h, required no output", OutInstr);
      end else begin
        e = sb_q.pop_front();
        check("out_instr", 64'(OutInstr), 64'(e.instr[31:7]));
        check("out_err", 64'(OutErr), 64'(e.err));
        if (!e.err && (e.src <= 3'd4))
          check("decode_roundtrip", 64'(decode({OutInstr, 7'b0}, e.src)), 64'(e.imm));
      end
    end
  end

  task automatic send(input logic [24:0] base, input logic [2:0] src, input logic [31:0] imm);
    int waited;
    bit done;
    waited = 0;
    done = 1'b0;
    InValid = 1'b1; InBase = base; InImmSrc = src; InImm = imm;
    while (!done) begin
      @(negedge clk);
      if (InReady) begin
        push_model(base, src, imm);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          compared++;
          mismatched++;
          $display("FAIL send_timeout: got InReady=0 for 50 cycles, required acceptance");
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    InValid = 1'b0;
  endtask

  task automatic drain();
    OutReady = 1'b1;
    for (int i = 0; i < 100 && (sb_q.size() != 0 || OutValid); i++) @(negedge clk);
    check("drain_left", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [24:0] rb;
    logic [2:0]  rs;
    logic [31:0] ri;
    bit pending;
    int stalls;
    reset = 1'b1; InValid = 1'b0; InBase = 25'd0; InImmSrc = 3'd0; InImm = 32'd0; OutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outvalid", 64'(OutValid), 64'd0);
    check("rst_outinstr", 64'(OutInstr), 64'd0);
    check("rst_outerr", 64'(OutErr), 64'd0);
    check("rst_errcount", 64'(ErrCount), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_inready", 64'(InReady), 64'd1);
    @(posedge clk); #1;

    // I-type -1 over base 0x00000500, then B-type +2046 over a zero base.
    send(25'h000000A, 3'd0, 32'hFFFFFFFF);
    @(negedge clk);
    check("i_latency_valid", 64'(OutValid), 64'd1);
    check("i_type_instr", 64'(OutInstr), 64'h1FFE00A);
    drain();
    send(25'h0000000, 3'd2, 32'h000007FE);
    @(negedge clk);
    check("b_type_instr", 64'(OutInstr), 64'h0FC001E);
    drain();
    send(25'h00ABCDE, 3'd2, 32'h00001001);
    drain();
    check("b_err_count", 64'(ErrCount), 64'd1);

    send(25'h0012345, 3'd3, 32'hFFFFFFFE);
    send(25'h1555555, 3'd4, 32'h12345000);
    send(25'h1555555, 3'd4, 32'h12345001);
    send(25'h0F0F0F0, 3'd5, 32'h00000000);
    send(25'h0F0F0F0, 3'd5, 32'h00000004);
    send(25'h0F0F0F0, 3'd7, 32'h00000000);
    send(25'h0F0F0F0, 3'd6, 32'h00000010);
    drain();
    check("directed_errcount", 64'(ErrCount), exp_errs());

    // Back-pressure: four offered, two accepted, then released in order.
    OutReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      InValid = 1'b1; InBase = 25'(k * 3 + 1); InImmSrc = 3'd0; InImm = 32'(k + 100);
      @(negedge clk);
      check("bp_inready", 64'(InReady), (k < 2) ? 64'd1 : 64'd0);
      if (InReady) push_model(InBase, InImmSrc, InImm);
      @(posedge clk); #1;
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    @(negedge clk); check("bp_out0_valid", 64'(OutValid), 64'd1);
    @(negedge clk); check("bp_out1_valid", 64'(OutValid), 64'd1);
    @(negedge clk); check("bp_empty", 64'(OutValid), 64'd0);
    @(posedge clk); #1;

    // Random traffic with random back-pressure.
    pending = 1'b0;
    rb = 25'd0; rs = 3'd0; ri = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pending && ($urandom_range(0, 3) != 0)) begin
        rb = 25'($urandom);
        rs = 3'($urandom_range(0, 7));
        ri = rand_imm();
        pending = 1'b1;
      end
      InValid = pending; InBase = rb; InImmSrc = rs; InImm = ri;
      OutReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (InValid && InReady) begin
        push_model(rb, rs, ri);
        pending = 1'b0;
      end
      @(posedge clk); #1;
    end
    InValid = 1'b0;
    drain();
    check("random_errcount", 64'(ErrCount), exp_errs());

    // 300 streamed illegal requests: full throughput and counter saturation.
    stalls = 0;
    OutReady = 1'b1;
    for (int n = 0; n < 300; n++) begin
      InValid = 1'b1; InBase = 25'($urandom); InImmSrc = 3'd7; InImm = $urandom;
      @(negedge clk);
      if (InReady) push_model(InBase, InImmSrc, InImm);
      else stalls++;
      @(posedge clk); #1;
    end
    InValid = 1'b0;
    drain();
    check("stream_stalls", 64'(stalls), 64'd0);
    check("sat_errcount", 64'(ErrCount), 64'd255);

    // Reset with two entries buffered.
    OutReady = 1'b0;
    send(25'h0000111, 3'd0, 32'h00000005);
    send(25'h0000222, 3'd1, 32'hFFFFFFF0);
    @(negedge clk);
    check("full_inready", 64'(InReady), 64'd0);
    check("full_outvalid", 64'(OutValid), 64'd1);
    #2;
    reset = 1'b1;
    sb_q.delete();
    model_errs = 0;
    #1;
    check("midrst_outvalid", 64'(OutValid), 64'd0);
    check("midrst_errcount", 64'(ErrCount), 64'd0);
    check("midrst_outinstr", 64'(OutInstr), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_inready", 64'(InReady), 64'd1);
    check("postrst_outvalid", 64'(OutValid), 64'd0);
    @(posedge clk); #1;
    OutReady = 1'b1;
    send(25'h0000333, 3'd4, 32'hABCDE000);
    send(25'h0000333, 3'd0, 32'h00000800);
    drain();
    check("postrst_errcount", 64'(ErrCount), exp_errs());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
